// File: rtl/regfile_port_arbiter_if.sv
// Signal bundle between the register-file write-port arbiter and its
// surroundings: CPU writeback, UART/debug requester, and the register file.
// The "master" modport is the surrounding system (requesters plus register
// file); the "slave" modport is the arbiter itself.
interface regfile_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // CPU writeback path
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_waddr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;

    // Debug requester, valid/ready handshake
    logic              dbg_valid;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ready;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    // Register file write port and debug read port
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;

    modport master (
        output cpu_we, cpu_waddr, cpu_wdata,
        input  cpu_stall,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  rf_we, rf_waddr, rf_wdata, rf_raddr,
        output rf_rdata
    );

    modport slave (
        input  cpu_we, cpu_waddr, cpu_wdata,
        output cpu_stall,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output rf_we, rf_waddr, rf_wdata, rf_raddr,
        input  rf_rdata
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter: shares the single write port and a debug read
// port between CPU writeback (normal priority) and a debug requester.
// A debug request that keeps losing to CPU writes for MAX_WAIT cycles forces
// a stall of the CPU so debug latency stays bounded. Writes to $0 are dropped.
// Optional feature macro: DBG_LOCK_EN adds a dbg_lock input that holds the CPU
// off the port entirely so debug can stream the whole register file.
module regfile_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic clock,
    input  logic reset,
`ifdef DBG_LOCK_EN
    input  logic dbg_lock,
`endif
    regfile_port_arbiter_if.slave bus
);

    localparam int             CNT_W   = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              txn_we_q, txn_we_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [ADDR_W-1:0] rf_raddr_q, rf_raddr_d;
    logic              dbg_ready_q, dbg_ready_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic lock_w;
    logic cpu_take;
    logic dbg_take;
    logic dbg_pending;

`ifdef DBG_LOCK_EN
    assign lock_w = dbg_lock;
`else
    assign lock_w = 1'b0;
`endif

    // A held request is not re-accepted in the cycle its completion pulse shows.
    assign dbg_pending = bus.dbg_valid && !dbg_ready_q;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        txn_we_d     = txn_we_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        rf_raddr_d   = rf_raddr_q;
        dbg_ready_d  = 1'b0;
        dbg_rvalid_d = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        cpu_take     = 1'b0;
        dbg_take     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_we && !lock_w) begin
                    cpu_take = 1'b1;
                    if (dbg_pending) begin
                        // This loss is the one that exhausts the wait budget.
                        if (wait_cnt_q >= LIMIT) begin
                            state_d = ST_STALL;
                        end
                        if (wait_cnt_q != CNT_MAX) begin
                            wait_cnt_d = wait_cnt_q + CNT_ONE;
                        end
                    end
                end else if (dbg_pending) begin
                    dbg_take = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_STALL: begin
                // A request withdrawn against the handshake rules is not invented.
                if (bus.dbg_valid) begin
                    dbg_take = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_DONE: begin
                dbg_ready_d  = 1'b1;
                dbg_rvalid_d = !txn_we_q;
                if (!txn_we_q) begin
                    dbg_rdata_d = bus.rf_rdata;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cpu_take) begin
            rf_we_d    = (bus.cpu_waddr != '0);
            rf_waddr_d = bus.cpu_waddr;
            rf_wdata_d = bus.cpu_wdata;
        end

        if (dbg_take) begin
            wait_cnt_d = '0;
            txn_we_d   = bus.dbg_we;
            rf_raddr_d = bus.dbg_addr;
            if (bus.dbg_we) begin
                rf_we_d    = (bus.dbg_addr != '0);
                rf_waddr_d = bus.dbg_addr;
                rf_wdata_d = bus.dbg_wdata;
            end
        end

        // The starvation count only measures an unbroken wait.
        if (!bus.dbg_valid) begin
            wait_cnt_d = '0;
        end
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            txn_we_q     <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            rf_raddr_q   <= '0;
            dbg_ready_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            txn_we_q     <= txn_we_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            rf_raddr_q   <= rf_raddr_d;
            dbg_ready_q  <= dbg_ready_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign bus.cpu_stall  = (state_q != ST_IDLE) || lock_w;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.rf_raddr   = rf_raddr_q;
    assign bus.dbg_ready  = dbg_ready_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

endmodule
